// File: rtl/cic_interp.sv
// cic_interp: CIC interpolator. STAGES comb stages clocked by CLKen_in, zero-stuffing,
// STAGES integrators clocked by CLKen_out, arithmetic right shift and 16-bit saturation.
// The rate ratio is set only by the spacing of the two strobes.
//
// Ports:
//   CLK        system clock
//   RSTn       asynchronous active-low reset (clears all state)
//   CLKen_in   low-rate strobe, samples SMPin
//   CLKen_out  high-rate strobe, advances integrators and SMPout
//   SMPin      signed 16-bit input sample
//   SMPout     signed 16-bit output sample (registered)
//   OVR        sticky overrun flag (registered)
module cic_interp #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned ACC_W  = 24,
    parameter int unsigned SHIFT  = 5
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               CLKen_in,
    input  logic               CLKen_out,
    input  logic signed [15:0] SMPin,
    output logic signed [15:0] SMPout,
    output logic               OVR
);

    localparam int unsigned SMP_W = 16;
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32'sd32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32'sd32768);

    // comb_q[k]: output of comb stage k; dly_q[k]: previous input of comb stage k
    logic signed [ACC_W-1:0] comb_q  [STAGES];
    logic signed [ACC_W-1:0] comb_d  [STAGES];
    logic signed [ACC_W-1:0] dly_q   [STAGES];
    logic signed [ACC_W-1:0] dly_d   [STAGES];
    logic signed [ACC_W-1:0] integ_q [STAGES];
    logic signed [ACC_W-1:0] integ_d [STAGES];
    logic signed [ACC_W-1:0] comb_in [STAGES];
    logic                    pend_q, pend_d;
    logic                    ovr_q,  ovr_d;
    logic signed [SMP_W-1:0] smp_q,  smp_d;
    logic signed [ACC_W-1:0] x_ext;
    logic signed [ACC_W-1:0] scaled;

    function automatic logic signed [SMP_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return 16'sh7fff;
        end else if (v < SAT_MIN) begin
            return 16'sh8000;
        end else begin
            return v[SMP_W-1:0];
        end
    endfunction

    assign x_ext  = {{(ACC_W-SMP_W){SMPin[SMP_W-1]}}, SMPin};
    assign scaled = integ_q[STAGES-1] >>> SHIFT;

    // Input of each comb stage: the sample for stage 0, previous stage output otherwise
    always_comb begin
        comb_in[0] = x_ext;
        for (int k = 1; k < int'(STAGES); k++) begin
            comb_in[k] = comb_q[k-1];
        end
    end

    // Next-state logic: combs on CLKen_in, integrators/output on CLKen_out, all from pre-edge values
    always_comb begin
        comb_d  = comb_q;
        dly_d   = dly_q;
        integ_d = integ_q;
        pend_d  = pend_q;
        ovr_d   = ovr_q;
        smp_d   = smp_q;

        if (CLKen_in) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                comb_d[k] = comb_in[k] - dly_q[k];
                dly_d[k]  = comb_in[k];
            end
        end

        if (CLKen_out) begin
            integ_d[0] = integ_q[0] + (pend_q ? comb_q[STAGES-1] : ACC_W'(0));
            for (int k = 1; k < int'(STAGES); k++) begin
                integ_d[k] = integ_q[k] + integ_q[k-1];
            end
            smp_d = sat16(scaled);
        end

        // A new sample always leaves PEND set, even when the old one is consumed on the same edge
        if (CLKen_in) begin
            pend_d = 1'b1;
        end else if (CLKen_out) begin
            pend_d = 1'b0;
        end

        // Overrun: a pending comb output is overwritten before any integrator consumed it
        if (CLKen_in && pend_q && !CLKen_out) begin
            ovr_d = 1'b1;
        end
    end

    // State registers
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                comb_q[k]  <= '0;
                dly_q[k]   <= '0;
                integ_q[k] <= '0;
            end
            pend_q <= 1'b0;
            ovr_q  <= 1'b0;
            smp_q  <= '0;
        end else begin
            comb_q  <= comb_d;
            dly_q   <= dly_d;
            integ_q <= integ_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            smp_q   <= smp_d;
        end
    end

    assign SMPout = smp_q;
    assign OVR    = ovr_q;

endmodule

// File: tb/tb_cic_interp.sv
// Testbench for cic_interp: two instances (SHIFT=5 and SHIFT=0) share stimulus.
// Expected outputs come from a closed-form model: the comb chain is an S-th order
// finite difference of the input sample history, and the integrator chain is an
// S-fold cumulative sum of the zero-stuffed sequence, expressed with binomial weights.
module tb_cic_interp;

    localparam int unsigned STAGES = 2;
    localparam int unsigned ACC_W  = 24;
    localparam int unsigned SH_A   = 5;
    localparam int unsigned SH_B   = 0;
    localparam int          NS     = int'(STAGES);
    localparam int          R      = 23;

    logic               CLK = 1'b0;
    logic               RSTn = 1'b0;
    logic               CLKen_in = 1'b0;
    logic               CLKen_out = 1'b0;
    logic signed [15:0] SMPin = '0;
    logic signed [15:0] smp_a, smp_b;
    logic               ovr_a, ovr_b;

    always #5 CLK = ~CLK;

    cic_interp #(.STAGES(STAGES), .ACC_W(ACC_W), .SHIFT(SH_A)) u_dut_a (
        .CLK(CLK), .RSTn(RSTn), .CLKen_in(CLKen_in), .CLKen_out(CLKen_out),
        .SMPin(SMPin), .SMPout(smp_a), .OVR(ovr_a)
    );

    cic_interp #(.STAGES(STAGES), .ACC_W(ACC_W), .SHIFT(SH_B)) u_dut_b (
        .CLK(CLK), .RSTn(RSTn), .CLKen_in(CLKen_in), .CLKen_out(CLKen_out),
        .SMPin(SMPin), .SMPout(smp_b), .OVR(ovr_b)
    );

    typedef struct {
        longint smp_a;
        longint smp_b;
        bit     ovr;
    } exp_t;

    exp_t   sb_q[$];
    int     checks = 0;
    int     errors = 0;
    longint xs[$];
    longint us[$];
    bit     m_pend = 1'b0;
    bit     m_ovr  = 1'b0;
    int     nz;
    longint peak;

    task automatic chk(input string nm, input longint act, input longint exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp_v, $time);
        end
    endtask

    function automatic longint wrap(input longint v);
        logic signed [ACC_W-1:0] t;
        t = v[ACC_W-1:0];
        return longint'(t);
    endfunction

    function automatic longint binom(input longint n, input int k);
        longint r;
        r = 1;
        if (n < longint'(k)) return 0;
        for (int i = 0; i < k; i++) r = r * (n - longint'(i)) / longint'(i + 1);
        return r;
    endfunction

    function automatic longint x_at(input int idx);
        if (idx < 0) return 0;
        return xs[idx];
    endfunction

    // Comb chain output: S-th difference of the samples, delayed by S-1 input strobes
    function automatic longint comb_out();
        int     n;
        longint s;
        n = xs.size() - 1;
        s = 0;
        if (n < 0) return 0;
        for (int j = 0; j <= NS; j++) begin
            s += ((j % 2 == 0) ? 64'sd1 : -64'sd1) * binom(longint'(NS), j) * x_at(n - (NS - 1) - j);
        end
        return wrap(s);
    endfunction

    // Value the output stage sees at the newest output strobe: S-fold cumulative sum of the
    // stuffed sequence, delayed by S-1 strobes behind the first integrator plus one output register
    function automatic longint integ_out();
        int     m;
        longint s;
        m = us.size() - 1;
        s = 0;
        for (int j = 0; j <= m - NS; j++) begin
            s += binom(longint'(m - 1 - j), NS - 1) * us[j];
        end
        return wrap(s);
    endfunction

    function automatic longint scale(input longint v, input int sh);
        longint y;
        y = v >>> sh;
        if (y > 32767) return 32767;
        if (y < -32768) return -32768;
        return y;
    endfunction

    task automatic model_reset();
        xs.delete();
        us.delete();
        sb_q.delete();
        m_pend = 1'b0;
        m_ovr  = 1'b0;
    endtask

    task automatic model_step(input bit ein, input bit eout, input logic signed [15:0] x);
        longint cpre;
        longint y;
        exp_t   e;
        cpre = comb_out();
        if (eout) us.push_back(m_pend ? cpre : 64'sd0);
        if (ein && m_pend && !eout) m_ovr = 1'b1;
        if (ein) xs.push_back(longint'(x));
        if (ein) m_pend = 1'b1;
        else if (eout) m_pend = 1'b0;
        if (eout) begin
            y = integ_out();
            e.smp_a = scale(y, int'(SH_A));
            e.smp_b = scale(y, int'(SH_B));
            e.ovr   = m_ovr;
            sb_q.push_back(e);
        end
    endtask

    task automatic tick(input bit ein, input bit eout, input logic signed [15:0] x);
        @(negedge CLK);
        CLKen_in  = ein;
        CLKen_out = eout;
        SMPin     = ein ? x : 16'($urandom());
        @(posedge CLK);
        model_step(ein, eout, x);
    endtask

    task automatic period(input logic signed [15:0] x);
        tick(1'b1, 1'b0, x);
        for (int k = 0; k < R; k++) tick(1'b0, 1'b1, 16'sd0);
    endtask

    task automatic period_collect(input logic signed [15:0] x);
        tick(1'b1, 1'b0, x);
        for (int k = 0; k < R; k++) begin
            tick(1'b0, 1'b1, 16'sd0);
            #1;
            if (smp_b != 0) nz++;
            if (longint'(smp_b) > peak) peak = longint'(smp_b);
        end
    endtask

    task automatic async_reset();
        @(negedge CLK);
        CLKen_in  = 1'b0;
        CLKen_out = 1'b0;
        #2;
        RSTn = 1'b0;
        #1;
        chk("rst_smp_a", longint'(smp_a), 0);
        chk("rst_smp_b", longint'(smp_b), 0);
        chk("rst_ovr", longint'(ovr_a), 0);
        chk("rst_pend", longint'(u_dut_a.pend_q), 0);
        model_reset();
        @(negedge CLK);
        RSTn = 1'b1;
    endtask

    // Monitor: on every honoured output strobe, pop the expected result and compare
    initial begin
        bit   o;
        bit   r;
        exp_t e;
        forever begin
            @(posedge CLK);
            o = CLKen_out;
            r = RSTn;
            #1;
            if (o && r) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_empty: got output strobe expected queued result at %0t", $time);
                end else begin
                    e = sb_q.pop_front();
                    chk("sb_smp_a", longint'(smp_a), e.smp_a);
                    chk("sb_smp_b", longint'(smp_b), e.smp_b);
                    chk("sb_ovr_a", longint'(ovr_a), longint'(e.ovr));
                    chk("sb_ovr_b", longint'(ovr_b), longint'(e.ovr));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        repeat (3) @(posedge CLK);
        #1;
        chk("init_smp_a", longint'(smp_a), 0);
        chk("init_smp_b", longint'(smp_b), 0);
        chk("init_ovr", longint'(ovr_a), 0);
        chk("init_pend", longint'(u_dut_a.pend_q), 0);
        @(negedge CLK);
        RSTn = 1'b1;

        // DC positive
        repeat (40) period(16'sd1000);
        #1;
        chk("dc_pos_a", longint'(smp_a), 718);
        chk("dc_pos_b", longint'(smp_b), 23000);
        chk("dc_pos_ovr", longint'(ovr_a), 0);

        // Reset in the middle of a period, then the DC run again
        repeat (5) period(16'sd1000);
        tick(1'b1, 1'b0, 16'sd1000);
        repeat (3) tick(1'b0, 1'b1, 16'sd0);
        async_reset();
        repeat (40) period(16'sd1000);
        #1;
        chk("dc_pos_after_rst", longint'(smp_a), 718);

        // DC negative
        repeat (40) period(-16'sd1000);
        #1;
        chk("dc_neg_a", longint'(smp_a), -719);
        chk("dc_neg_ovr", longint'(ovr_a), 0);

        // Impulse into the unshifted instance
        repeat (6) period(16'sd0);
        #1;
        chk("impulse_pre", longint'(smp_b), 0);
        nz   = 0;
        peak = 0;
        period_collect(16'sd1024);
        repeat (4) period_collect(16'sd0);
        chk("impulse_nonzero", longint'(nz), 45);
        chk("impulse_peak", peak, 23552);
        chk("impulse_tail", longint'(smp_b), 0);

        // Saturation, then a step back to zero
        repeat (8) period(16'sd32767);
        #1;
        chk("sat_b", longint'(smp_b), 32767);
        chk("sat_a", longint'(smp_a), 23551);
        repeat (8) period(16'sd0);
        #1;
        chk("sat_release_b", longint'(smp_b), 0);
        chk("sat_release_a", longint'(smp_a), 0);

        // Coincident strobes with a pending sample: no overrun, new sample pending
        tick(1'b1, 1'b0, 16'sd300);
        tick(1'b1, 1'b1, -16'sd200);
        #1;
        chk("coinc_ovr", longint'(ovr_a), 0);
        chk("coinc_pend", longint'(u_dut_a.pend_q), 1);
        repeat (R) tick(1'b0, 1'b1, 16'sd0);
        repeat (3) period(16'sd0);
        #1;
        chk("coinc_ovr_later", longint'(ovr_a), 0);

        // Overrun: two input strobes with no output strobe between
        tick(1'b1, 1'b0, 16'sd500);
        tick(1'b1, 1'b0, -16'sd500);
        #1;
        chk("ovr_set_a", longint'(ovr_a), 1);
        chk("ovr_set_b", longint'(ovr_b), 1);
        repeat (3) period(16'sd0);
        #1;
        chk("ovr_sticky", longint'(ovr_a), 1);

        // Randomized strobes and samples from a clean start
        async_reset();
        for (int n = 0; n < 3000; n++) begin
            tick(($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 16'($urandom()));
        end
        tick(1'b0, 1'b0, 16'sd0);
        #1;
        chk("sb_drained", longint'(sb_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
